tomar_orden: RTL and testbench
==============================

# tomar_orden

Order-entry front end for the order-delivery pipeline: takes operator button presses to choose one of four menu items, accumulates coin credit, and, once the price is covered and the delivery stage reports it is idle, issues a single-cycle `enable` pulse that launches delivery. It sits directly upstream of the delivery FSM. Its `listo` input is driven by that stage's "order received" indicator (Y2), and its `enable` output drives that stage's `enable`.

## Interface
Parameters:
- `CREDIT_W`, 4: width of credit and change registers.
- `TIMEOUT`, 50: cycles without a coin edge in PAGO before automatic cancel (only with `TOMAR_ORDEN_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sel`  in  1  item-select button; already synchronized to `clk`.
- `coin`  in  1  coin pulse button; one credit unit per rising edge.
- `cancel`  in  1  cancel button.
- `listo`  in  1  downstream stage idle and ready to accept an order.
- `enable`  out  1  one-cycle launch pulse to the delivery stage.
- `item`  out  2  currently selected item, 0..3.
- `credit`  out  CREDIT_W  accumulated credit.
- `change`  out  CREDIT_W  change owed from the last completed order.
- `refund`  out  1  one-cycle pulse when an order is abandoned with credit > 0.
- `order_count`  out  8  completed orders, wraps 255 -> 0.
- `Y1`  out  1  payment LED, high while in PAGO.

## Operation
- Edge detection: each of `sel`, `coin`, `cancel` has a registered previous sample. An edge is "sampled 1 now, 0 at the previous clock edge". A held button yields exactly one edge.
- States (3-bit): ESPERA=000, SELECCION=001, PAGO=010, LISTA=011. Codes 100–111 go to ESPERA.
- ESPERA: `credit` = 0. A `sel` edge moves to SELECCION with `item` = 0.
- SELECCION: a `sel` edge sets `item` = (`item`+1) mod 4. A `coin` edge moves to PAGO and adds 1 to credit. A `cancel` edge moves to ESPERA with no refund.
- PAGO priority, highest first:
  - A `cancel` edge moves to ESPERA. `refund` pulses if credit > 0, and credit clears.
  - A `coin` edge increments credit, saturating at 2^CREDIT_W−1. If the new credit ≥ PRICE[item], the FSM moves to LISTA on the same edge.
- LISTA waits for `listo` = 1. On the first edge with `listo` = 1:
  - `enable` = 1 for one cycle;
  - `change` = credit − PRICE[item];
  - `order_count` increments;
  - credit clears and the FSM goes to ESPERA.
  - `cancel` in LISTA behaves as in PAGO: refund and return to ESPERA.
- Coin edges outside SELECCION and PAGO are ignored.
- `change` holds its value until the next completed order or reset.
- `credit` never wraps.

## Timing
- All outputs are registered. An input change sampled at clock edge k appears on outputs after edge k.
- `enable` is asserted during the cycle after the edge where LISTA ∧ `listo` was sampled. It is never high two consecutive cycles.
- Minimum latency from the final coin edge to `enable` is 2 edges, if `listo` is already high.
- Reset values: state = ESPERA, `item` = 0, `credit` = 0, `change` = 0, `order_count` = 0, `enable` = 0, `refund` = 0, `Y1` = 0; edge registers = 0.
- Reset mid-operation discards credit without a `refund` pulse.
- Simultaneous `coin` and `cancel` edges: cancel wins and the coin is not counted.
- Simultaneous `sel` and `coin` edges in SELECCION: the coin wins and `item` is unchanged.

## Configuration
- `TOMAR_ORDEN_TIMEOUT_EN` defined:
  - An idle counter runs in PAGO and clears on every coin edge.
  - When it reaches TIMEOUT−1, the FSM behaves as a cancel edge: it moves to ESPERA and pulses `refund`.
- `TOMAR_ORDEN_TIMEOUT_EN` undefined: no counter exists and PAGO waits indefinitely.

## Structure
- Package `tomar_orden_pkg` holds:
  - the state encodings;
  - the price table PRICE = {3, 5, 7, 9} for items 0..3;
  - the item-count constant 4.
- Sub-module `detector_flanco` is a one-bit rising-edge detector with `clk` and `reset`, instantiated three times.

## Test plan
- Reset, then sel edge, coin ×3: `item` = 0, credit 1→2→3, LISTA entered. With `listo` = 1, `enable` pulses once, `change` = 0, `order_count` = 1.
- sel ×3 (item = 2, price 7), coin ×9 with `listo` = 0, then `listo` = 1 after 5 cycles: credit stops at 7 (LISTA entered on the 7th coin), extra coins are ignored, `enable` follows `listo`, `change` = 0.
- item = 3, coin ×4, then cancel: `refund` pulses one cycle, credit = 0, state ESPERA, `order_count` unchanged.
- Coin and cancel edges on the same cycle in PAGO with credit = 2: cancel wins, credit = 0, refund pulses.
- Held `coin` high for 20 cycles: credit increments exactly once.
- With `TOMAR_ORDEN_TIMEOUT_EN`, TIMEOUT = 50, credit = 1: after 50 idle cycles the FSM is in ESPERA and refund pulses. Without the macro, it is still in PAGO after 200 cycles.

Source files
------------

// File: rtl/tomar_orden_pkg.sv
// -----------------------------------------------------------------------------
// tomar_orden_pkg
// Shared definitions for the order-entry front end:
//   - estado_t : FSM state encodings (3-bit, codes 100..111 are unused)
//   - N_ITEMS  : number of menu items
//   - PRICE    : price table, indexed by item
//   - price_of : table lookup helper
// -----------------------------------------------------------------------------
package tomar_orden_pkg;

   typedef enum logic [2:0] {
      ESPERA    = 3'b000,
      SELECCION = 3'b001,
      PAGO      = 3'b010,
      LISTA     = 3'b011
   } estado_t;

   localparam int unsigned N_ITEMS = 4;
   localparam int unsigned PRICE_W = 4;

   localparam logic [PRICE_W-1:0] PRICE [N_ITEMS] = '{4'd3, 4'd5, 4'd7, 4'd9};

   function automatic logic [PRICE_W-1:0] price_of(input logic [1:0] item);
      return PRICE[item];
   endfunction

endpackage

// File: rtl/tomar_orden_detector_flanco.sv
// -----------------------------------------------------------------------------
// detector_flanco
// One-bit rising-edge detector. The input is assumed already synchronous
// to clk. flanco is high while d is 1 and was 0 at the previous clock edge,
// so a held input produces exactly one edge.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high reset (previous sample clears to 0)
//   d      in  sampled input
//   flanco out rising-edge indication (combinational from d and previous)
// -----------------------------------------------------------------------------
module detector_flanco (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic flanco
);

   logic d_prev;

   // NOTE: registered state is written with <= so every flop samples the
   // pre-edge values; a blocking = here would make ordering between
   // always_ff blocks change the hardware.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) d_prev <= 1'b0;
      else       d_prev <= d;
   end

   assign flanco = d & ~d_prev;

endmodule

// File: rtl/tomar_orden.sv
// -----------------------------------------------------------------------------
// tomar_orden
// Order-entry front end: the operator picks one of four items with sel,
// inserts coins, and once the price is covered and the delivery stage
// reports idle (listo, driven by the delivery FSM's Y2), a single-cycle
// enable launches delivery.
//
// Optional feature: define TOMAR_ORDEN_TIMEOUT_EN to cancel an order that
// sits in PAGO for TIMEOUT cycles without a coin edge (with refund).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   sel          in   item-select button (synchronous)
//   coin         in   coin pulse, one credit unit per rising edge
//   cancel       in   cancel button
//   listo        in   delivery stage idle, ready for an order
//   enable       out  one-cycle launch pulse to the delivery stage
//   item         out  selected item, 0..3
//   credit       out  accumulated credit (saturating)
//   change       out  change from the last completed order
//   refund       out  one-cycle pulse when an order with credit is dropped
//   order_count  out  completed orders, wraps 255 -> 0
//   Y1           out  payment LED, high while in PAGO
// -----------------------------------------------------------------------------
module tomar_orden
   import tomar_orden_pkg::*;
#(
   parameter int unsigned CREDIT_W = 4,
   parameter int unsigned TIMEOUT  = 50
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sel,
   input  logic                coin,
   input  logic                cancel,
   input  logic                listo,
   output logic                enable,
   output logic [1:0]          item,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] change,
   output logic                refund,
   output logic [7:0]          order_count,
   output logic                Y1
);

   estado_t             state;
   logic                sel_edge, coin_edge, cancel_edge;
   logic [CREDIT_W-1:0] price;
   logic [CREDIT_W-1:0] credit_inc;
   logic [1:0]          item_next;
   logic                timeout_hit;

   detector_flanco u_det_sel    (.clk(clk), .reset(reset), .d(sel),    .flanco(sel_edge));
   detector_flanco u_det_coin   (.clk(clk), .reset(reset), .d(coin),   .flanco(coin_edge));
   detector_flanco u_det_cancel (.clk(clk), .reset(reset), .d(cancel), .flanco(cancel_edge));

   assign price      = CREDIT_W'(price_of(item));
   // Credit saturates at all-ones instead of wrapping.
   assign credit_inc = (&credit) ? credit : credit + CREDIT_W'(1);
   assign item_next  = (item == 2'(N_ITEMS - 1)) ? 2'd0 : item + 2'd1;

`ifdef TOMAR_ORDEN_TIMEOUT_EN
   localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [IDLE_W-1:0] idle_cnt;

   // Counts PAGO cycles since entry or the last coin edge; held at zero
   // everywhere else so each PAGO visit starts fresh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             idle_cnt <= '0;
      else if (state != PAGO || coin_edge)   idle_cnt <= '0;
      else if (!timeout_hit)                 idle_cnt <= idle_cnt + IDLE_W'(1);
   end

   // A coin on the expiring cycle keeps the order alive.
   assign timeout_hit = (state == PAGO) && !coin_edge &&
                        (idle_cnt == IDLE_W'(TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ESPERA;
         item        <= '0;
         credit      <= '0;
         change      <= '0;
         order_count <= '0;
         enable      <= 1'b0;
         refund      <= 1'b0;
         Y1          <= 1'b0;
      end else begin
         // Pulse outputs default low; branches raise them for one cycle.
         enable <= 1'b0;
         refund <= 1'b0;

         case (state)
            ESPERA: begin
               credit <= '0;
               Y1     <= 1'b0;
               if (sel_edge) begin
                  state <= SELECCION;
                  item  <= '0;
               end
            end

            // Priority: cancel, then coin, then sel (a simultaneous coin
            // leaves the item unchanged).
            SELECCION: begin
               if (cancel_edge) begin
                  state <= ESPERA;
               end else if (coin_edge) begin
                  state  <= PAGO;
                  credit <= credit_inc;
                  Y1     <= 1'b1;
               end else if (sel_edge) begin
                  item <= item_next;
               end
            end

            PAGO: begin
               if (cancel_edge || timeout_hit) begin
                  state  <= ESPERA;
                  refund <= (credit != '0);
                  credit <= '0;
                  Y1     <= 1'b0;
               end else if (coin_edge) begin
                  credit <= credit_inc;
                  if (credit_inc >= price) begin
                     state <= LISTA;
                     Y1    <= 1'b0;
                  end
               end
            end

            // Coins are ignored here; only cancel or listo leave.
            LISTA: begin
               if (cancel_edge) begin
                  state  <= ESPERA;
                  refund <= (credit != '0);
                  credit <= '0;
               end else if (listo) begin
                  state       <= ESPERA;
                  enable      <= 1'b1;
                  change      <= credit - price;
                  order_count <= order_count + 8'd1;
                  credit      <= '0;
               end
            end

            default: begin
               state  <= ESPERA;
               credit <= '0;
               Y1     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tomar_orden.sv
// -----------------------------------------------------------------------------
// tb_tomar_orden
// Self-checking bench for tomar_orden. The stimulus process pushes the
// expected enable/refund pulses into a scoreboard queue; a monitor pops and
// compares whenever the DUT raises enable or refund. Static outputs are
// checked directly after each stimulus step. Define TOMAR_ORDEN_TIMEOUT_EN
// to exercise the timeout build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tomar_orden;

   localparam int unsigned CREDIT_W = 4;
   localparam int unsigned TIMEOUT  = 50;

   logic                clk = 1'b0;
   logic                reset;
   logic                sel, coin, cancel, listo;
   logic                enable, refund, Y1;
   logic [1:0]          item;
   logic [CREDIT_W-1:0] credit, change;
   logic [7:0]          order_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      bit         is_enable;
      logic [7:0] count;
      logic [3:0] chg;
   } exp_t;

   exp_t sb[$];

   tomar_orden #(.CREDIT_W(CREDIT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .sel(sel), .coin(coin), .cancel(cancel),
      .listo(listo), .enable(enable), .item(item), .credit(credit),
      .change(change), .refund(refund), .order_count(order_count), .Y1(Y1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One cycle with the given buttons high, then one cycle all released.
   task automatic press(input logic s, input logic c, input logic x);
      sel = s; coin = c; cancel = x;
      tick();
      sel = 1'b0; coin = 1'b0; cancel = 1'b0;
      tick();
   endtask

   task automatic push_enable(input logic [7:0] cnt, input logic [3:0] chg);
      exp_t e;
      e.is_enable = 1'b1; e.count = cnt; e.chg = chg;
      sb.push_back(e);
   endtask

   task automatic push_refund(input logic [7:0] cnt);
      exp_t e;
      e.is_enable = 1'b0; e.count = cnt; e.chg = '0;
      sb.push_back(e);
   endtask

   // Monitor: every enable/refund pulse must match the next queued event.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (enable || refund)) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", {30'd0, enable, refund}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("pulse_kind", {30'd0, enable, refund},
                     e.is_enable ? 32'd2 : 32'd1);
               check("pulse_order_count", order_count, e.count);
               if (e.is_enable) check("pulse_change", change, e.chg);
               check("pulse_credit", credit, 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; sel = 1'b0; coin = 1'b0; cancel = 1'b0; listo = 1'b0;
      tick(2);
      check("rst_enable", enable, 0);
      check("rst_refund", refund, 0);
      check("rst_item", item, 0);
      check("rst_credit", credit, 0);
      check("rst_change", change, 0);
      check("rst_order_count", order_count, 0);
      check("rst_Y1", Y1, 0);
      reset = 1'b0;
      tick();

      // Test 1: item 0 (price 3), three coins, listo already high.
      listo = 1'b1;
      press(1, 0, 0);
      check("t1_item", item, 0);
      check("t1_Y1_sel", Y1, 0);
      press(0, 1, 0);
      check("t1_credit1", credit, 1);
      check("t1_Y1_pago", Y1, 1);
      press(0, 1, 0);
      check("t1_credit2", credit, 2);
      push_enable(8'd1, 4'd0);
      press(0, 1, 0);
      check("t1_order_count", order_count, 1);
      check("t1_change", change, 0);
      check("t1_credit_clr", credit, 0);
      check("t1_Y1_off", Y1, 0);

      // Test 2: item 2 (price 7), nine coins with listo low.
      listo = 1'b0;
      repeat (3) press(1, 0, 0);
      check("t2_item", item, 2);
      for (int i = 1; i <= 9; i++) begin
         press(0, 1, 0);
         check($sformatf("t2_credit_%0d", i), credit, (i < 7) ? i : 7);
      end
      check("t2_Y1_lista", Y1, 0);
      tick(5);
      check("t2_waiting_count", order_count, 1);
      push_enable(8'd2, 4'd0);
      listo = 1'b1;
      tick(2);
      check("t2_order_count", order_count, 2);
      check("t2_change", change, 0);
      check("t2_credit_clr", credit, 0);

      // Test 3: item 3, four coins, cancel with refund.
      repeat (4) press(1, 0, 0);
      check("t3_item", item, 3);
      repeat (4) press(0, 1, 0);
      check("t3_credit", credit, 4);
      check("t3_Y1", Y1, 1);
      push_refund(8'd2);
      press(0, 0, 1);
      check("t3_credit_clr", credit, 0);
      check("t3_Y1_off", Y1, 0);
      check("t3_order_count", order_count, 2);

      // Test 4: item wrap, sel+coin collision, coin+cancel collision.
      repeat (5) press(1, 0, 0);
      check("t4_item_wrap", item, 0);
      press(1, 0, 0);
      check("t4_item1", item, 1);
      press(1, 1, 0);
      check("t4_item_kept", item, 1);
      check("t4_credit1", credit, 1);
      press(0, 1, 0);
      check("t4_credit2", credit, 2);
      push_refund(8'd2);
      press(0, 1, 1);
      check("t4_credit_clr", credit, 0);
      check("t4_Y1_off", Y1, 0);

      // Test 5: coin held high for 20 cycles counts once.
      press(1, 0, 0);
      coin = 1'b1;
      tick(20);
      check("t5_held_credit", credit, 1);
      coin = 1'b0;
      tick();
      check("t5_credit_after", credit, 1);
      check("t5_Y1", Y1, 1);

`ifdef TOMAR_ORDEN_TIMEOUT_EN
      push_refund(8'd2);
      press(0, 0, 1);
      check("t5_cancel_credit", credit, 0);

      // Test 6: timeout after TIMEOUT idle cycles in PAGO.
      press(1, 0, 0);
      coin = 1'b1;
      tick();
      coin = 1'b0;
      tick(TIMEOUT - 1);
      check("t6_still_pago", Y1, 1);
      check("t6_credit", credit, 1);
      push_refund(8'd2);
      tick();
      check("t6_timeout_Y1", Y1, 0);
      check("t6_timeout_credit", credit, 0);
`else
      // Test 6: without timeout, PAGO waits indefinitely.
      tick(200);
      check("t6_still_pago", Y1, 1);
      check("t6_credit", credit, 1);
      push_refund(8'd2);
      press(0, 0, 1);
      check("t6_cancel_credit", credit, 0);
`endif

      // Test 7: reset mid-payment discards credit, no refund.
      press(1, 0, 0);
      press(0, 1, 0);
      press(0, 1, 0);
      check("t7_credit", credit, 2);
      reset = 1'b1;
      tick(2);
      check("t7_rst_credit", credit, 0);
      check("t7_rst_Y1", Y1, 0);
      check("t7_rst_count", order_count, 0);
      check("t7_rst_item", item, 0);
      reset = 1'b0;
      tick(5);

      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
